// File: rtl/stream_demux_pkg.sv
// ============================================================================
// Module : stream_demux_pkg
// Brief  : Route-select constants and steering helper shared by the demux.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package stream_demux_pkg;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // True when the effective select targets the given slot.
  function automatic logic sel_hit(input logic es, input logic slot_sel);
    return es == slot_sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stream_demux_hold_slot.sv
// ============================================================================
// Module : hold_slot
// Brief  : One-entry output holding register with valid/ready handshake.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hold_slot #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             drain,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic             can_accept
);

  logic [WIDTH-1:0] data_d, data_q;
  logic             valid_d, valid_q;

  // A reload in the drain cycle wins over the clear, keeping the slot full.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (valid_q && drain) valid_d = 1'b0;
    if (load) begin
      valid_d = 1'b1;
      data_d  = d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign q          = data_q;
  assign valid      = valid_q;
  assign can_accept = !valid_q || drain;

endmodule

`default_nettype wire

// File: rtl/stream_demux.sv
// ============================================================================
// Module : stream_demux
// Brief  : Registered 1-to-2 stream demultiplexer with per-output holding slot.
//          Define STREAM_DEMUX_ALTERNATE_EN to route strictly A, B, A, B...
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready
);

  logic es;
  logic a_can, b_can;
  logic a_load, b_load;
  logic xfer_in;

`ifdef STREAM_DEMUX_ALTERNATE_EN
  logic t_d, t_q;

  // The toggle only advances on an accepted word, so a stall holds the target.
  always_comb begin
    t_d = t_q;
    if (xfer_in) t_d = !t_q;
  end

  always_ff @(posedge clk) begin
    if (rst) t_q <= 1'b0;
    else     t_q <= t_d;
  end

  assign es = t_q;
  wire unused_in_sel = in_sel;
`else
  assign es = in_sel;
`endif

  assign in_ready = !rst && (sel_hit(es, SEL_B) ? b_can : a_can);
  assign xfer_in  = in_valid && in_ready;
  assign a_load   = xfer_in && sel_hit(es, SEL_A);
  assign b_load   = xfer_in && sel_hit(es, SEL_B);

  hold_slot #(.WIDTH(WIDTH)) u_slot_a (
    .clk        (clk),
    .rst        (rst),
    .load       (a_load),
    .drain      (a_ready),
    .d          (in_data),
    .q          (a_data),
    .valid      (a_valid),
    .can_accept (a_can)
  );

  hold_slot #(.WIDTH(WIDTH)) u_slot_b (
    .clk        (clk),
    .rst        (rst),
    .load       (b_load),
    .drain      (b_ready),
    .d          (in_data),
    .q          (b_data),
    .valid      (b_valid),
    .can_accept (b_can)
  );

endmodule

`default_nettype wire

// File: tb/tb_stream_demux.sv
// Scoreboard bench for stream_demux (WIDTH=8); alternate-mode tests build
// when STREAM_DEMUX_ALTERNATE_EN is defined.
`default_nettype none

module tb_stream_demux;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_sel;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_data, b_data;
  logic         a_valid, b_valid;
  logic         a_ready, b_ready;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_a[$];
  logic [W-1:0] exp_b[$];
  logic         tb_t = 1'b0;

  stream_demux #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_data   (a_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .b_data   (b_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every handshake on an output pops and compares its scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (a_valid && a_ready) begin
        checks++;
        if (exp_a.size() == 0) begin
          errors++;
          $display("FAIL out_a unexpected actual=%0h expected=none", a_data);
        end else begin
          automatic logic [W-1:0] e = exp_a.pop_front();
          if (a_data !== e) begin
            errors++;
            $display("FAIL out_a actual=%0h expected=%0h", a_data, e);
          end
        end
      end
      if (b_valid && b_ready) begin
        checks++;
        if (exp_b.size() == 0) begin
          errors++;
          $display("FAIL out_b unexpected actual=%0h expected=none", b_data);
        end else begin
          automatic logic [W-1:0] e = exp_b.pop_front();
          if (b_data !== e) begin
            errors++;
            $display("FAIL out_b actual=%0h expected=%0h", b_data, e);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic route(input logic sel);
`ifdef STREAM_DEMUX_ALTERNATE_EN
    return tb_t;
`else
    return sel;
`endif
  endfunction

  // Offer one word, wait (bounded) for acceptance, then push the expectation.
  task automatic send(input logic [W-1:0] d, input logic sel);
    logic ok;
    logic r;
    ok = 1'b0;
    in_data  = d;
    in_sel   = sel;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      step();
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=stalled required=accept data=%0h", d);
    end else begin
      r = route(sel);
      if (r) exp_b.push_back(d);
      else   exp_a.push_back(d);
      tb_t = ~tb_t;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    exp_a.delete();
    exp_b.delete();
    tb_t = 1'b0;
  endtask

  task automatic drain_all();
    a_ready = 1'b1;
    b_ready = 1'b1;
    repeat (4) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    in_data = '0; in_sel = 1'b0; in_valid = 1'b0;
    a_ready = 1'b0; b_ready = 1'b0;
    do_reset();

    // Reset with both slots full and both sinks ready.
    send(8'h5A, 1'b0);
    send(8'hA5, 1'b1);
    chk("full_a_before_rst", {31'd0, a_valid}, 32'd1);
    chk("full_b_before_rst", {31'd0, b_valid}, 32'd1);
    rst = 1'b1; a_ready = 1'b1; b_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h77; in_sel = 1'b0;
    @(negedge clk);
    chk("in_ready_in_rst", {31'd0, in_ready}, 32'd0);
    step();
    chk("rst_a_valid", {31'd0, a_valid}, 32'd0);
    chk("rst_b_valid", {31'd0, b_valid}, 32'd0);
    chk("rst_a_data", {24'd0, a_data}, 32'h00);
    chk("rst_b_data", {24'd0, b_data}, 32'h00);
    in_valid = 1'b0;
    rst = 1'b0;
    exp_a.delete(); exp_b.delete(); tb_t = 1'b0;
    step();

`ifndef STREAM_DEMUX_ALTERNATE_EN
    // Basic routing with one-cycle latency.
    send(8'h11, 1'b0);
    chk("lat_a_valid", {31'd0, a_valid}, 32'd1);
    chk("lat_a_data", {24'd0, a_data}, 32'h11);
    send(8'h22, 1'b1);
    chk("lat_b_valid", {31'd0, b_valid}, 32'd1);
    chk("lat_b_data", {24'd0, b_data}, 32'h22);
    drain_all();

    // Slot A stalled: second word for A blocks until the sink drains.
    a_ready = 1'b0;
    send(8'h33, 1'b0);
    in_data = 8'h44; in_sel = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_a_in_ready", {31'd0, in_ready}, 32'd0);
      step();
    end
    a_ready = 1'b1;
    @(negedge clk);
    chk("unstall_a_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    exp_a.push_back(8'h44);
    in_valid = 1'b0;
    send(8'h55, 1'b1);
    drain_all();

    // B proceeds while A is full and stalled.
    a_ready = 1'b0;
    b_ready = 1'b1;
    send(8'h66, 1'b0);
    send(8'h55, 1'b1);
    chk("b_past_stall_valid", {31'd0, b_valid}, 32'd1);
    chk("b_past_stall_data", {24'd0, b_data}, 32'h55);
    chk("a_still_held", {24'd0, a_data}, 32'h66);
    drain_all();

    // Drain and reload of slot A in the same cycle.
    a_ready = 1'b0;
    send(8'hAA, 1'b0);
    a_ready = 1'b1;
    send(8'hBB, 1'b0);
    chk("reload_a_valid", {31'd0, a_valid}, 32'd1);
    chk("reload_a_data", {24'd0, a_data}, 32'hBB);
    drain_all();
`else
    // Alternating routing ignores in_sel.
    a_ready = 1'b1; b_ready = 1'b1;
    send(8'h01, 1'b1);
    send(8'h02, 1'b1);
    send(8'h03, 1'b0);
    send(8'h04, 1'b0);
    send(8'h05, 1'b1);
    send(8'h06, 1'b0);
    drain_all();

    // Stall on B blocks the input even though A is free; toggle holds.
    send(8'h01, 1'b0);
    b_ready = 1'b0;
    send(8'h02, 1'b0);
    send(8'h03, 1'b1);
    in_data = 8'h04; in_sel = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("alt_stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("alt_stall_t", {31'd0, dut.t_q}, 32'd1);
      step();
    end
    b_ready = 1'b1;
    @(negedge clk);
    chk("alt_unstall_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    exp_b.push_back(8'h04);
    tb_t = ~tb_t;
    in_valid = 1'b0;
    drain_all();

    // Reset mid-stream restarts routing at A.
    send(8'h05, 1'b1);
    do_reset();
    send(8'h06, 1'b1);
    chk("alt_restart_a_valid", {31'd0, a_valid}, 32'd1);
    chk("alt_restart_a_data", {24'd0, a_data}, 32'h06);
    chk("alt_restart_b_valid", {31'd0, b_valid}, 32'd0);
    drain_all();
`endif

    chk("exp_a_empty", exp_a.size(), 32'd0);
    chk("exp_b_empty", exp_b.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stream_demux.md
# stream_demux

Registered 1-to-2 stream demultiplexer: the distributing counterpart of the two-input mux. One producer stream is steered by a select bit into one of two consumer streams. Each output has a one-entry holding slot and a valid/ready handshake. It sits between a single result source, such as the ALU writeback path, and two independent sinks, for example the register file and the I/O port. Full throughput is sustained while the selected sink keeps up.

## Interface
Parameters:
- WIDTH, 1, data width in bits (matches the mux default)

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  reset, synchronous and active-high
- in_data  in  WIDTH  incoming word
- in_sel  in  1  route select: 0 → output a, 1 → output b; ignored when STREAM_DEMUX_ALTERNATE_EN is defined
- in_valid  in  1  producer offers in_data/in_sel
- in_ready  out  1  block accepts the offered word this cycle
- a_data  out  WIDTH  slot A word
- a_valid  out  1  slot A holds a word
- a_ready  in  1  sink A takes the word
- b_data, b_valid, b_ready: same as the A ports, for slot B

## Operation
- Effective select: `es` = in_sel. In alternate mode, `es` = the internal toggle bit `t`.
- Slot X can accept when it is empty, or when it is full and being drained this cycle (x_valid & x_ready). The accept condition is combinational from the sink's ready.
- in_ready = can-accept of slot A when es=0; can-accept of slot B when es=1.
- Transfer in: in_valid & in_ready. On a transfer in, the selected slot loads in_data and sets valid. The other slot is untouched.
- Transfer out of slot X: x_valid & x_ready. It clears valid unless the same slot reloads in that cycle.
- Same slot drained and reloaded in one cycle: the slot stays valid and holds the new word.
- Both slots may drain in the same cycle, independently of each other.
- in_valid=0: no slot loads, and x_data holds its previous value.
- x_data is only meaningful while x_valid=1.
- A producer must hold in_data/in_sel stable while in_valid=1 & in_ready=0. The block does not check this.
- No data width conversion; words pass through bit-exact.

## Timing
- Reset (rst=1 at an edge): a_valid=0, b_valid=0, a_data=0, b_data=0, t=0. Any held words are discarded.
- With rst=1, in_ready is forced to 0 regardless of slot state. The block accepts nothing during the reset cycle.
- Latency: a word accepted at edge n appears on x_data/x_valid after edge n, i.e. one cycle.
- Throughput: one word per cycle while the selected sink holds ready=1.
- A blocked output does not stall a transfer to the other output. in_sel=1 proceeds while slot A is full and stalled.
- A reset asserted while a slot is full and its sink is ready still clears the slot. The word counts as not transferred.

## Configuration
- STREAM_DEMUX_ALTERNATE_EN defined:
  - in_sel is ignored.
  - es = t, with t reset to 0.
  - t inverts on every transfer in, so words go strictly A, B, A, B…
  - A stall on the targeted slot holds t and stalls the input, even if the other slot is empty.
- Not defined: t is not present, and routing follows in_sel only.

## Structure
- Constants include file holds SEL_A=1'b0 and SEL_B=1'b1, shared with the mux users.
- Sub-module `hold_slot`:
  - one-entry register of WIDTH bits plus a valid flop
  - inputs: load, drain, d
  - outputs: q, valid, can_accept
  - instantiated twice
- Steering logic reuses the existing invert/selmux primitives for es/!es gating.

## Test plan
(All with WIDTH=8.)
1. Reset: assert rst with both slots full → after one edge a_valid=b_valid=0 and a_data=b_data=0x00; in_ready=0 while rst=1.
2. Basic routing: send 0x11 with sel=0, then 0x22 with sel=1, both sinks ready → a shows 0x11 one cycle later, b shows 0x22 the cycle after; no loss.
3. Independent stall: a_ready=0, send 0x33 (sel=0) then 0x44 (sel=0), then 0x55 (sel=1) →
   - 0x33 held in slot A
   - in_ready=0 for 0x44
   - 0x55 is not offered until 0x44 transfers (in-order producer)
   - re-run with 0x55 first → b gets 0x55 while A is stalled
4. Drain+reload: slot A full with 0xAA, a_ready=1, offer 0xBB sel=0 in the same cycle → next cycle a_valid=1, a_data=0xBB; 0xAA counted once.
5. Alternate mode (macro defined): stream 0x01–0x06 with random sel, sinks always ready → A receives 01, 03, 05 and B receives 02, 04, 06.
6. Alternate stall: macro defined, b_ready=0 after 0x02 reaches B → 0x03 goes to A, 0x04 blocks with in_ready=0 until b_ready=1 and t unchanged during the block; reset mid-stream restarts at A.
